// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the instruction/data memory port arbiter.
package mem_arb_pkg;

  // Width of the consecutive-D-grant counter (holds 0..15)
  localparam int STREAK_W = 4;

  // Owner of the read response arriving in the following cycle
  typedef enum logic [1:0] {
    OWNER_NONE = 2'd0,
    OWNER_I    = 2'd1,
    OWNER_D    = 2'd2
  } owner_e;

  // Increment that sticks at the ceiling instead of wrapping
  function automatic logic [STREAK_W-1:0] sat_inc(input logic [STREAK_W-1:0] val,
                                                  input logic [STREAK_W-1:0] ceil);
    logic [STREAK_W-1:0] res;
    if (val >= ceil) begin
      res = ceil;
    end else begin
      res = val + 4'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/arb_streak_ctr.sv
// arb_streak_ctr: counts consecutive data-port grants taken while a fetch is
// waiting and raises force_i once the limit is reached, so the fetch port
// cannot be starved by a busy data port.
module arb_streak_ctr
  import mem_arb_pkg::*;
#(
  parameter int MAX_D_STREAK = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_req,
  input  logic i_gnt,
  input  logic d_gnt,
  output logic force_i
);

  localparam logic [STREAK_W-1:0] MAX_S = STREAK_W'(MAX_D_STREAK);

  logic [STREAK_W-1:0] streak_r;
  logic [STREAK_W-1:0] streak_nxt_s;

  // Next streak: reset whenever the fetch side is served or not waiting
  always_comb begin
    streak_nxt_s = streak_r;
    if (i_gnt || !i_req) begin
      streak_nxt_s = {STREAK_W{1'b0}};
    end else if (d_gnt) begin
      streak_nxt_s = sat_inc(streak_r, MAX_S);
    end else begin
      streak_nxt_s = streak_r;
    end
  end

  // Streak register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      streak_r <= {STREAK_W{1'b0}};
    end else begin
      streak_r <= streak_nxt_s;
    end
  end

  assign force_i = i_req & (streak_r == MAX_S);

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port synchronous memory between the
// instruction-fetch port (I) and the data port (D). D has priority, bounded by
// a starvation limit that forces an I grant. Read data returns one cycle after
// the grant and is steered to the port that owned the access.
// Optional build macro: ARB_STATS_EN adds grant/conflict statistics counters.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MAX_D_STREAK = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_gnt,
  output logic                i_rvalid,
  output logic [DATA_W-1:0]   i_rdata,
  input  logic                d_req,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wstrb,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                m_en,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  input  logic [DATA_W-1:0]   m_rdata
`ifdef ARB_STATS_EN
  ,
  output logic [31:0]         stat_i_grants,
  output logic [31:0]         stat_d_grants,
  output logic [31:0]         stat_conflicts
`endif
);

  localparam int STRB_W = DATA_W / 8;

  logic   force_i_s;
  logic   i_gnt_s;
  logic   d_gnt_s;
  owner_e owner_r;
  owner_e owner_nxt_s;

  // An all-zero strobe marks a read access
  function automatic logic is_read(input logic [STRB_W-1:0] strb);
    return (strb == {STRB_W{1'b0}});
  endfunction

  arb_streak_ctr #(
    .MAX_D_STREAK(MAX_D_STREAK)
  ) u_streak (
    .clk     (clk),
    .reset_n (reset_n),
    .i_req   (i_req),
    .i_gnt   (i_gnt_s),
    .d_gnt   (d_gnt_s),
    .force_i (force_i_s)
  );

  // Grant decision: D first unless the streak limit forces I; nothing during reset
  always_comb begin
    d_gnt_s = reset_n & d_req & ~force_i_s;
    i_gnt_s = reset_n & i_req & ~d_gnt_s;
  end

  assign i_gnt = i_gnt_s;
  assign d_gnt = d_gnt_s;
  assign m_en  = i_gnt_s | d_gnt_s;

  // Memory request mux: fetches are always reads, idle cycles drive zeros
  always_comb begin
    m_addr  = {ADDR_W{1'b0}};
    m_wdata = {DATA_W{1'b0}};
    m_wstrb = {STRB_W{1'b0}};
    if (d_gnt_s) begin
      m_addr  = d_addr;
      m_wdata = d_wdata;
      m_wstrb = d_wstrb;
    end else if (i_gnt_s) begin
      m_addr  = i_addr;
    end else begin
      m_addr  = {ADDR_W{1'b0}};
    end
  end

  // Owner of next cycle's read data; writes produce no response
  always_comb begin
    owner_nxt_s = OWNER_NONE;
    if (i_gnt_s) begin
      owner_nxt_s = OWNER_I;
    end else if (d_gnt_s && is_read(d_wstrb)) begin
      owner_nxt_s = OWNER_D;
    end else begin
      owner_nxt_s = OWNER_NONE;
    end
  end

  // Owner register; a reset drops any response still in flight
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      owner_r <= OWNER_NONE;
    end else begin
      owner_r <= owner_nxt_s;
    end
  end

  assign i_rvalid = (owner_r == OWNER_I);
  assign d_rvalid = (owner_r == OWNER_D);
  assign i_rdata  = i_rvalid ? m_rdata : {DATA_W{1'b0}};
  assign d_rdata  = d_rvalid ? m_rdata : {DATA_W{1'b0}};

`ifdef ARB_STATS_EN
  logic [31:0] stat_i_r;
  logic [31:0] stat_d_r;
  logic [31:0] stat_c_r;

  // Free-running statistics counters, wrapping at 2^32
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_i_r <= 32'd0;
      stat_d_r <= 32'd0;
      stat_c_r <= 32'd0;
    end else begin
      if (i_gnt_s) begin
        stat_i_r <= stat_i_r + 32'd1;
      end
      if (d_gnt_s) begin
        stat_d_r <= stat_d_r + 32'd1;
      end
      if (i_req && d_req) begin
        stat_c_r <= stat_c_r + 32'd1;
      end
    end
  end

  assign stat_i_grants  = stat_i_r;
  assign stat_d_grants  = stat_d_r;
  assign stat_conflicts = stat_c_r;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed vector table, hand sequence and randomized
// run against a behavioural model of the arbiter. Honours ARB_STATS_EN.
module tb_mem_port_arbiter;

  localparam int MAX = 4;

  logic        clk;
  logic        reset_n;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_gnt;
  logic        i_rvalid;
  logic [31:0] i_rdata;
  logic        d_req;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_wstrb;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        m_en;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic [31:0] m_rdata;
`ifdef ARB_STATS_EN
  logic [31:0] stat_i_grants;
  logic [31:0] stat_d_grants;
  logic [31:0] stat_conflicts;
`endif

  int tests;
  int failures;

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MAX_D_STREAK(MAX)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_en(m_en), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_rdata(m_rdata)
`ifdef ARB_STATS_EN
    , .stat_i_grants(stat_i_grants), .stat_d_grants(stat_d_grants), .stat_conflicts(stat_conflicts)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s.%s: got 0x%0h expected 0x%0h", tag, name, act, exp);
    end
  endtask

  // Compare every output against the expected grants/valids and current inputs
  task automatic check_outputs(input string tag, input logic eig, input logic edg,
                               input logic eiv, input logic edv);
    logic [31:0] ea;
    logic [31:0] ew;
    logic [3:0]  es;
    ea = edg ? d_addr : (eig ? i_addr : 32'd0);
    ew = edg ? d_wdata : 32'd0;
    es = edg ? d_wstrb : 4'd0;
    chk(tag, "i_gnt",    32'(i_gnt),    32'(eig));
    chk(tag, "d_gnt",    32'(d_gnt),    32'(edg));
    chk(tag, "m_en",     32'(m_en),     32'(eig | edg));
    chk(tag, "m_addr",   m_addr,        ea);
    chk(tag, "m_wdata",  m_wdata,       ew);
    chk(tag, "m_wstrb",  32'(m_wstrb),  32'(es));
    chk(tag, "i_rvalid", 32'(i_rvalid), 32'(eiv));
    chk(tag, "d_rvalid", 32'(d_rvalid), 32'(edv));
    chk(tag, "i_rdata",  i_rdata,       eiv ? m_rdata : 32'd0);
    chk(tag, "d_rdata",  d_rdata,       edv ? m_rdata : 32'd0);
  endtask

  typedef struct {
    logic       rn;
    logic       ir;
    logic       dr;
    logic [3:0] strb;
    logic       ig;
    logic       dg;
    logic       iv;
    logic       dv;
  } vec_t;

  localparam int NVEC = 20;
  vec_t tbl [NVEC];

  // Reference model state
  int          d_run;    // D grants taken back-to-back while I was waiting
  int          pending;  // 0: no response, 1: fetch response, 2: data response
  logic [31:0] n_i, n_d, n_c;

  initial begin
    logic eig, edg, eiv, edv, frc;
    tests    = 0;
    failures = 0;
    reset_n  = 1'b0;
    i_req    = 1'b0;
    d_req    = 1'b0;
    i_addr   = 32'd0;
    d_addr   = 32'd0;
    d_wdata  = 32'd0;
    d_wstrb  = 4'd0;
    m_rdata  = 32'd0;

    //          rn    ir    dr    strb   ig    dg    iv    dv
    tbl[0]  = '{1'b0, 1'b1, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 1'b1, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 1'b1, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[3]  = '{1'b1, 1'b1, 1'b1, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[4]  = '{1'b1, 1'b1, 1'b1, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[5]  = '{1'b1, 1'b1, 1'b1, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[6]  = '{1'b1, 1'b1, 1'b1, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[7]  = '{1'b1, 1'b1, 1'b1, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[8]  = '{1'b1, 1'b1, 1'b1, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[9]  = '{1'b1, 1'b1, 1'b1, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[10] = '{1'b1, 1'b1, 1'b1, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[11] = '{1'b1, 1'b0, 1'b1, 4'h3, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[12] = '{1'b1, 1'b0, 1'b1, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[13] = '{1'b1, 1'b0, 1'b1, 4'hF, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[14] = '{1'b1, 1'b0, 1'b1, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[15] = '{1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[16] = '{1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[17] = '{1'b1, 1'b1, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[18] = '{1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[19] = '{1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0};

    // Directed vectors: reset hold, D,D,D,D,I pattern, write/read mix, reset after I grant
    for (int v = 0; v < NVEC; v++) begin
      @(negedge clk);
      reset_n = tbl[v].rn;
      i_req   = tbl[v].ir;
      d_req   = tbl[v].dr;
      i_addr  = 32'h10;
      d_addr  = 32'h20;
      d_wdata = 32'h12345678;
      d_wstrb = tbl[v].strb;
      m_rdata = $urandom;
      #1;
      check_outputs($sformatf("vec%0d", v), tbl[v].ig, tbl[v].dg, tbl[v].iv, tbl[v].dv);
    end
`ifdef ARB_STATS_EN
    chk("vec19", "stat_i", stat_i_grants, 32'd0);
    chk("vec19", "stat_d", stat_d_grants, 32'd0);
    chk("vec19", "stat_c", stat_conflicts, 32'd0);
`endif

    // Hand sequence: reset, then fetch-only for 3 cycles with fixed memory data
    @(negedge clk);
    reset_n = 1'b0;
    i_req   = 1'b0;
    d_req   = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      reset_n = 1'b1;
      i_req   = (c < 3);
      i_addr  = 32'h10;
      d_wstrb = 4'h0;
      m_rdata = 32'hAABBCCDD;
      #1;
      check_outputs($sformatf("ionly%0d", c), (c < 3), 1'b0, (c > 0), 1'b0);
    end

    // Randomized run against the behavioural model (starts from a fresh reset)
    @(negedge clk);
    reset_n = 1'b0;
    i_req   = 1'b0;
    d_req   = 1'b0;
    d_run   = 0;
    pending = 0;
    n_i = 32'd0; n_d = 32'd0; n_c = 32'd0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      reset_n = ($urandom_range(0, 99) != 0);
      i_req   = ($urandom_range(0, 3) != 0);
      d_req   = ($urandom_range(0, 3) != 0);
      i_addr  = $urandom;
      d_addr  = $urandom;
      d_wdata = $urandom;
      d_wstrb = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      m_rdata = $urandom;
      #1;
      if (!reset_n) begin
        check_outputs($sformatf("rnd%0d", k), 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef ARB_STATS_EN
        chk("rnd", "stat_i", stat_i_grants, 32'd0);
`endif
        d_run   = 0;
        pending = 0;
        n_i = 32'd0; n_d = 32'd0; n_c = 32'd0;
      end else begin
        frc = i_req && (d_run == MAX);
        edg = d_req && !frc;
        eig = i_req && !edg;
        eiv = (pending == 1);
        edv = (pending == 2);
        check_outputs($sformatf("rnd%0d", k), eig, edg, eiv, edv);
`ifdef ARB_STATS_EN
        chk("rnd", "stat_i", stat_i_grants, n_i);
        chk("rnd", "stat_d", stat_d_grants, n_d);
        chk("rnd", "stat_c", stat_conflicts, n_c);
`endif
        if (eig) n_i = n_i + 32'd1;
        if (edg) n_d = n_d + 32'd1;
        if (i_req && d_req) n_c = n_c + 32'd1;
        if (eig) pending = 1;
        else if (edg && d_wstrb == 4'h0) pending = 2;
        else pending = 0;
        if (eig || !i_req) d_run = 0;
        else if (edg && d_run < MAX) d_run = d_run + 1;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
